// File: rtl/gray_seq_ctrl.sv
// Command-driven gray-coded position sequencer: accepts a move (direction, step count)
// and steps a binary position once every DWELL+1 cycles, publishing its gray encoding.
module gray_seq_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DWELL = 2
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [WIDTH-1:0] cmd_steps,
    input  logic             abort,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             step_strobe,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int unsigned DW = 8;
    localparam logic [DW-1:0] DWELL_V = DW'(DWELL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_WAIT,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic             dir_q, dir_d;
    logic             strobe_q, strobe_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        rem_d     = rem_q;
        dwell_d   = dwell_q;
        dir_d     = dir_q;
        strobe_d  = 1'b0;
        aborted_d = aborted_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    dir_d     = cmd_dir;
                    rem_d     = cmd_steps;
                    aborted_d = 1'b0;
                    state_d   = (cmd_steps == '0) ? S_DONE : S_STEP;
                end
            end
            S_STEP: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    bin_d    = dir_q ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));
                    rem_d    = rem_q - WIDTH'(1);
                    strobe_d = 1'b1;
                    if (rem_d == '0) begin
                        state_d = S_DONE;
                    end else if (DWELL_V == '0) begin
                        state_d = S_STEP;
                    end else begin
                        dwell_d = DWELL_V;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (dwell_q <= DW'(1)) begin
                    dwell_d = '0;
                    state_d = S_STEP;
                end else begin
                    dwell_d = dwell_q - DW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        gray_d  = bin_d ^ (bin_d >> 1);
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q   <= S_IDLE;
            bin_q     <= '0;
            gray_q    <= '0;
            rem_q     <= '0;
            dwell_q   <= '0;
            dir_q     <= 1'b0;
            strobe_q  <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            gray_q    <= gray_d;
            rem_q     <= rem_d;
            dwell_q   <= dwell_d;
            dir_q     <= dir_d;
            strobe_q  <= strobe_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign bin_out     = bin_q;
    assign gray_out    = gray_q;
    assign step_strobe = strobe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;

endmodule
